serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_arith_pkg.sv | 15 +
 rtl/full_sub.sv | 15 +
 rtl/serial_subtractor.sv | 101 ++++++++++
 tb/tb_serial_subtractor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// default operand width.
package serial_arith_pkg;

    // Sequencer states of a bit-serial operation.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Operand/result width used when the instantiating code does not override it.
    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: x - y - bin, producing difference bit and borrow.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference is the three-way parity; a borrow is needed when y exceeds x,
    // or when they are equal and a borrow is already pending.
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit pair per clock, LSB first.
// A start in IDLE captures a and b; WIDTH clocks later done pulses for one
// cycle with diff = (a - b) mod 2^WIDTH and borrow_out = (a < b).
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH + 1);
    // The result register only needs the first WIDTH-1 bits; the final bit
    // comes straight from the subtractor stage on the completing edge.
    localparam int RW = WIDTH - 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sub_state_t       state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [RW-1:0]    res_reg;
    logic             br_reg;
    logic [CW-1:0]    cnt_reg;

    logic             d_bit;
    logic             bout_bit;

    // The single combinational bit stage, fed by the operand LSBs and the
    // running borrow.
    full_sub u_full_sub (
        .x    (a_sr_reg[0]),
        .y    (b_sr_reg[0]),
        .bin  (br_reg),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // Sequencer, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_reg    <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr_reg  <= a;
                        b_sr_reg  <= b;
                        res_reg   <= '0;
                        br_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_sr_reg <= a_sr_reg >> 1;
                    b_sr_reg <= b_sr_reg >> 1;
                    br_reg   <= bout_bit;
                    cnt_reg  <= cnt_reg + CW'(1);
                    // New bit enters at the top; the bottom bit falls off.
                    res_reg  <= RW'({d_bit, res_reg} >> 1);
                    if (cnt_reg == LAST_BIT) begin
                        diff       <= {d_bit, res_reg};
                        borrow_out <= bout_bit;
                        done       <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: the stimulus side pushes the
// arithmetic result and expected completion cycle, a monitor pops on done.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         br;
        int unsigned  due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int          n_done = 0;
    int          n_expected = 0;
    int          busy_len = 0;
    bit          aborted = 1'b0;

    // Rising-edge counter used to time the expected completions.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference arithmetic: plain unsigned subtraction and comparison.
    task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb, input int unsigned due);
        exp_t x;
        logic [W:0] full;
        full   = {1'b0, ea} - {1'b0, eb};
        x.a    = ea;
        x.b    = eb;
        x.diff = full[W-1:0];
        x.br   = (ea < eb);
        x.due  = due;
        exp_q.push_back(x);
        n_expected++;
    endtask

    // Call at a falling edge with the DUT idle; start is seen on the next rising edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
        start = 1'b1;
        a     = ia;
        b     = ib;
        push_exp(ia, ib, cyc + 1 + W);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    // Monitor: compare each completion against the scoreboard and track busy width.
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", {31'b0, done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("diff", {24'b0, diff}, {24'b0, e.diff});
                check("borrow_out", {31'b0, borrow_out}, {31'b0, e.br});
                check("done_cycle", cyc, e.due);
                $display("op a=%02h b=%02h diff=%02h borrow=%0b at cycle %0d", e.a, e.b, diff, borrow_out, cyc);
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
            check("missing_done", {31'b0, done}, 32'd1);
            void'(exp_q.pop_front());
        end
        if (busy) begin
            busy_len++;
        end else if (busy_len != 0) begin
            if (!aborted) check("busy_cycles", busy_len, W + 1);
            busy_len = 0;
            aborted  = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset with start asserted: start must be ignored.
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_diff", {24'b0, diff}, 32'd0);
        check("rst_borrow", {31'b0, borrow_out}, 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("no_start_after_rst", {31'b0, busy}, 32'd0);

        // Directed operand pairs.
        issue(8'h35, 8'h12); wait_idle();
        issue(8'h12, 8'h35); wait_idle();
        issue(8'h00, 8'h01); wait_idle();
        issue(8'hFF, 8'hFF); wait_idle();

        // Start re-pulsed and operands changed during RUN.
        issue(8'h5A, 8'hA7);
        repeat (2) @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // Reset pulse in the middle of RUN aborts the operation.
        issue(8'hC3, 8'h3C);
        repeat (4) @(negedge clk);
        rst_n   = 1'b0;
        aborted = 1'b1;
        exp_q.delete();
        n_expected--;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_diff", {24'b0, diff}, 32'd0);
        check("abort_borrow", {31'b0, borrow_out}, 32'd0);
        repeat (W + 2) @(negedge clk);
        issue(8'h80, 8'h01); wait_idle();

        // Start held high: operations follow each other W+2 edges apart.
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            push_exp(a, b, cyc + 1 + W);
            @(negedge clk);
            if (i == 3) start = 1'b0;
            repeat (W + 1) @(negedge clk);
        end
        wait_idle();

        // Random operands with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 7 == 0) rb = ra;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(ra, rb);
            wait_idle();
        end

        repeat (W + 4) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        check("done_count", n_done, n_expected);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
